// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate controller.
package parking_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_OPEN,
      S_EVENT,
      S_CLOSE,
      S_REJECT
   } gate_state_e;

   localparam int OPEN_HOUR_DEFAULT = 8;
   localparam int UNI_CAPACITY      = 500;
   localparam int GEN_CAPACITY      = 200;

endpackage

// File: rtl/parking_gate_fsm.sv
// One barrier sequencer; IS_ENTRY selects admission checks or free exit.
// Optional open timeout is built when GATE_TIMEOUT_EN is defined.
module parking_gate_fsm
   import parking_pkg::*;
#(
   parameter bit IS_ENTRY       = 1'b1,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int OPEN_HOUR      = OPEN_HOUR_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] i_current_hour,
   input  logic       i_request,
   input  logic       i_is_uni,
   input  logic       i_pass,
   input  logic       i_uni_vacant,
   input  logic       i_vacant,
   input  logic       i_granted,
   output logic       o_open,
   output logic       o_is_uni,
   output logic       o_denied,
   output logic       o_evt_req,
   output logic       o_timeout_hit
);

   gate_state_e r_state;
   logic        r_open;
   logic        r_is_uni;
   logic        r_denied;
   logic        w_admit;
   logic        w_to;

   assign w_admit = (i_current_hour >= 5'(OPEN_HOUR)) &&
                    (i_vacant || (r_is_uni && i_uni_vacant));

   // Asks the arbiter for a strobe in the cycle we will spend in EVENT.
   assign o_evt_req = ((r_state == S_OPEN) && i_pass) ||
                      ((r_state == S_EVENT) && !i_granted);

`ifdef GATE_TIMEOUT_EN
   localparam int TW = ($clog2(TIMEOUT_CYCLES) > 10) ?
                       $clog2(TIMEOUT_CYCLES) : 10;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] r_timer;

   assign w_to = (r_state == S_OPEN) && !i_pass && (r_timer == T_LAST);
`else
   assign w_to = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_open   <= 1'b0;
         r_is_uni <= 1'b0;
         r_denied <= 1'b0;
`ifdef GATE_TIMEOUT_EN
         r_timer  <= '0;
`endif
      end else begin
         r_denied <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (i_request) begin
                  r_is_uni <= i_is_uni;
                  r_state  <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (!IS_ENTRY || w_admit) begin
                  r_state <= S_OPEN;
                  r_open  <= 1'b1;
`ifdef GATE_TIMEOUT_EN
                  r_timer <= '0;
`endif
               end else begin
                  r_denied <= 1'b1;
                  r_state  <= S_REJECT;
               end
            end
            S_OPEN: begin
               if (i_pass) begin
                  r_state <= S_EVENT;
                  r_open  <= 1'b0;
               end else if (w_to) begin
                  r_state <= S_CLOSE;
                  r_open  <= 1'b0;
               end
`ifdef GATE_TIMEOUT_EN
               else if (r_timer != '1) begin
                  r_timer <= r_timer + 1'b1;
               end
`endif
            end
            S_EVENT: begin
               if (i_granted) r_state <= S_CLOSE;
            end
            S_CLOSE: begin
               if (!i_request && !i_pass) r_state <= S_IDLE;
            end
            S_REJECT: begin
               if (!i_request) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_open        = r_open;
   assign o_is_uni      = r_is_uni;
   assign o_denied      = r_denied;
   assign o_timeout_hit = w_to;

endmodule

// File: rtl/parking_gate_controller.sv
// Entry/exit barrier pair with a shared event arbiter (exit has priority).
// Open timeout is present only when GATE_TIMEOUT_EN is defined.
module parking_gate_controller
   import parking_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int OPEN_HOUR      = OPEN_HOUR_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] i_current_hour,
   input  logic       i_entry_request,
   input  logic       i_entry_is_uni,
   input  logic       i_entry_pass,
   input  logic       i_exit_request,
   input  logic       i_exit_is_uni,
   input  logic       i_exit_pass,
   input  logic       i_uni_is_vacated_space,
   input  logic       i_is_vacated_space,
   output logic       o_entry_open,
   output logic       o_exit_open,
   output logic       o_car_entered,
   output logic       o_car_exited,
   output logic       o_is_uni_car_entered,
   output logic       o_is_uni_car_exited,
   output logic       o_entry_denied,
   output logic       o_gate_timeout
);

   logic w_ent_evt;
   logic w_ext_evt;
   logic w_ent_to;
   logic w_ext_to;
   logic w_ent_grant;
   logic r_car_entered;
   logic r_car_exited;
   logic r_gate_timeout;

   parking_gate_fsm #(
      .IS_ENTRY       (1'b1),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .OPEN_HOUR      (OPEN_HOUR)
   ) u_entry (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_current_hour (i_current_hour),
      .i_request      (i_entry_request),
      .i_is_uni       (i_entry_is_uni),
      .i_pass         (i_entry_pass),
      .i_uni_vacant   (i_uni_is_vacated_space),
      .i_vacant       (i_is_vacated_space),
      .i_granted      (r_car_entered),
      .o_open         (o_entry_open),
      .o_is_uni       (o_is_uni_car_entered),
      .o_denied       (o_entry_denied),
      .o_evt_req      (w_ent_evt),
      .o_timeout_hit  (w_ent_to)
   );

   parking_gate_fsm #(
      .IS_ENTRY       (1'b0),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .OPEN_HOUR      (OPEN_HOUR)
   ) u_exit (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_current_hour (i_current_hour),
      .i_request      (i_exit_request),
      .i_is_uni       (i_exit_is_uni),
      .i_pass         (i_exit_pass),
      .i_uni_vacant   (i_uni_is_vacated_space),
      .i_vacant       (i_is_vacated_space),
      .i_granted      (r_car_exited),
      .o_open         (o_exit_open),
      .o_is_uni       (o_is_uni_car_exited),
      .o_denied       (),
      .o_evt_req      (w_ext_evt),
      .o_timeout_hit  (w_ext_to)
   );

   // An entry strobe waits a cycle whenever an exit strobe is due.
   assign w_ent_grant = w_ent_evt && !w_ext_evt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_car_entered  <= 1'b0;
         r_car_exited   <= 1'b0;
         r_gate_timeout <= 1'b0;
      end else begin
         r_car_entered  <= w_ent_grant;
         r_car_exited   <= w_ext_evt;
         r_gate_timeout <= w_ent_to | w_ext_to;
      end
   end

   assign o_car_entered  = r_car_entered;
   assign o_car_exited   = r_car_exited;
   assign o_gate_timeout = r_gate_timeout;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller (both GATE_TIMEOUT_EN builds).
module tb_parking_gate_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] hour = 5'd9;
   logic       ent_req = 0, ent_uni = 0, ent_pass = 0;
   logic       ext_req = 0, ext_uni = 0, ext_pass = 0;
   logic       uni_vac = 1, vac = 1;
   logic       ent_open, ext_open, entered, exited;
   logic       uni_ent, uni_ext, denied, tmo;

   int n_checks = 0;
   int n_pass   = 0;
   int strobes;

   always #5 clk = ~clk;

   parking_gate_controller #(
      .TIMEOUT_CYCLES (16),
      .OPEN_HOUR      (8)
   ) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .i_current_hour         (hour),
      .i_entry_request        (ent_req),
      .i_entry_is_uni         (ent_uni),
      .i_entry_pass           (ent_pass),
      .i_exit_request         (ext_req),
      .i_exit_is_uni          (ext_uni),
      .i_exit_pass            (ext_pass),
      .i_uni_is_vacated_space (uni_vac),
      .i_is_vacated_space     (vac),
      .o_entry_open           (ent_open),
      .o_exit_open            (ext_open),
      .o_car_entered          (entered),
      .o_car_exited           (exited),
      .o_is_uni_car_entered   (uni_ent),
      .o_is_uni_car_exited    (uni_ext),
      .o_entry_denied         (denied),
      .o_gate_timeout         (tmo)
   );

   task automatic check(input string tag,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic entry_pass_through();
      ent_pass = 1;
      tick(2);
      ent_req  = 0;
      ent_pass = 0;
      tick(2);
   endtask

   initial begin
      tick(2);
      check("rst_open", {ent_open, ext_open}, 2'b00);
      check("rst_strobes", {entered, exited, denied, tmo}, 4'h0);
      check("rst_uni", {uni_ent, uni_ext}, 2'b00);
      rst_n = 1;
      tick(1);

      // Admitted uni entry, strobe one cycle after pass
      hour = 9; ent_uni = 1; ent_req = 1;
      tick(1);
      check("t1_check_closed", ent_open, 1'b0);
      tick(1);
      check("t1_open", ent_open, 1'b1);
      tick(2);
      ent_pass = 1;
      tick(1);
      check("t1_entered", entered, 1'b1);
      check("t1_uni", uni_ent, 1'b1);
      check("t1_bar_low", ent_open, 1'b0);
      tick(1);
      check("t1_single", entered, 1'b0);
      check("t1_uni_hold", uni_ent, 1'b1);
      ent_pass = 0; ent_req = 0;
      tick(2);

      // Too early: denied, stays closed until request drops
      hour = 7; ent_uni = 0; ent_req = 1;
      tick(1);
      check("t2_no_deny_yet", denied, 1'b0);
      tick(1);
      check("t2_denied", denied, 1'b1);
      check("t2_closed", ent_open, 1'b0);
      hour = 9;
      tick(1);
      check("t2_deny_pulse", denied, 1'b0);
      tick(4);
      check("t2_held_closed", ent_open, 1'b0);
      check("t2_no_redeny", denied, 1'b0);
      ent_req = 0;
      tick(1);
      ent_req = 1;
      tick(2);
      check("t2_rerequest_open", ent_open, 1'b1);
      entry_pass_through();

      // Uni car falls back on the general vacancy flag
      hour = 14; uni_vac = 0; vac = 1; ent_uni = 1; ent_req = 1;
      tick(2);
      check("t3_fallback_open", ent_open, 1'b1);
      entry_pass_through();
      vac = 0; ent_req = 1;
      tick(2);
      check("t3_full_denied", {denied, ent_open}, 2'b10);
      ent_req = 0;
      tick(2);

      // Coincident passes: exit first, entry next cycle
      uni_vac = 1; vac = 1; ent_uni = 0; ext_uni = 1;
      ent_req = 1; ext_req = 1;
      tick(2);
      check("t4_both_open", {ent_open, ext_open}, 2'b11);
      ent_pass = 1; ext_pass = 1;
      tick(1);
      check("t4_k1", {exited, entered}, 2'b10);
      check("t4_bars_low", {ent_open, ext_open}, 2'b00);
      check("t4_uni_ext", uni_ext, 1'b1);
      tick(1);
      check("t4_k2", {exited, entered}, 2'b01);
      check("t4_uni_ent", uni_ent, 1'b0);
      tick(1);
      check("t4_k3", {exited, entered}, 2'b00);
      ent_req = 0; ext_req = 0; ent_pass = 0; ext_pass = 0;
      tick(2);

`ifdef GATE_TIMEOUT_EN
      // No pass: closes after 16 open cycles
      ext_req = 1;
      tick(2);
      check("t5_open", ext_open, 1'b1);
      tick(15);
      check("t5_still_open", {ext_open, tmo}, 2'b10);
      tick(1);
      check("t5_timeout", {ext_open, tmo, exited}, 3'b010);
      tick(1);
      check("t5_tmo_pulse", tmo, 1'b0);
      ext_req = 0;
      tick(2);
`else
      // No pass: barrier holds open indefinitely
      ext_req = 1;
      tick(2);
      tick(120);
      check("t5_hold_open", {ext_open, tmo}, 2'b10);
      ext_pass = 1;
      tick(1);
      check("t5_late_exit", exited, 1'b1);
      ext_pass = 0; ext_req = 0;
      tick(2);
`endif

      // Async reset while exit is in EVENT
      ext_uni = 1; ext_req = 1;
      tick(2);
      ext_pass = 1;
      tick(1);
      check("t6_pre_rst", exited, 1'b1);
      rst_n = 0;
      #1;
      check("t6_rst_strobe", exited, 1'b0);
      check("t6_rst_outs", {ext_open, uni_ext, ent_open}, 3'b000);
      ext_req = 0; ext_pass = 0;
      #2;
      rst_n = 1;
      tick(2);
      check("t6_no_replay", exited, 1'b0);
      ext_uni = 0; ext_req = 1;
      tick(2);
      check("t6_reopen", ext_open, 1'b1);
      ext_pass = 1;
      strobes = 0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         if (exited) strobes++;
      end
      check("t6_one_strobe", strobes, 1);
      ext_req = 0; ext_pass = 0;
      tick(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/parking_gate_controller.md
# parking_gate_controller

Drives the entry and exit barriers of the parking lot and produces the `car_entered` / `car_exited` event strobes, with `is_uni_car_*` qualifiers, that the parking management counter consumes. Entry admission is decided from the counter's `uni_is_vacated_space` / `is_vacated_space` flags and `current_hour`. Each barrier is sequenced by a small FSM with a pass-sensor handshake and an optional open timeout. The block is the producing end of the event interface; the counter is the consuming end.

## Interface
- `TIMEOUT_CYCLES`, default 1000: cycles a barrier stays open waiting for the pass sensor before closing with no event.
- `OPEN_HOUR`, default 8: first hour, inclusive, at which entry is admitted.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `current_hour`  in  5: hour of day, 0–23.
- `entry_request`  in  1: car present at the entry barrier; level.
- `entry_is_uni`  in  1: entry badge is a university car; sampled with the request.
- `entry_pass`  in  1: entry pass sensor; level, high while the car is under the barrier.
- `exit_request`, `exit_is_uni`, `exit_pass`  in  1 each: exit-side equivalents.
- `uni_is_vacated_space`, `is_vacated_space`  in  1 each: vacancy flags from the counter.
- `entry_open`, `exit_open`  out  1 each: barrier drive; high means open.
- `car_entered`, `car_exited`  out  1 each: single-cycle event strobes.
- `is_uni_car_entered`, `is_uni_car_exited`  out  1 each: latched badge type; valid in and after the strobe cycle.
- `entry_denied`, `gate_timeout`  out  1 each: single-cycle status strobes.

## Operation
- Two independent gate FSMs, one entry and one exit, share one event arbiter.
- FSM states: IDLE, CHECK, OPEN, EVENT, CLOSE, REJECT.
- **IDLE**
  - `*_request`=1 → CHECK.
  - Latch `*_is_uni` into `is_uni_car_*`.
- **CHECK (entry)**
  - Admit when `current_hour`>=`OPEN_HOUR` and the vacancy rule holds:
    - uni car: `uni_is_vacated_space` OR `is_vacated_space`;
    - other car: `is_vacated_space`.
  - Admit → OPEN. Otherwise pulse `entry_denied` and go to REJECT.
- **CHECK (exit)**: always → OPEN. No hour or vacancy gating.
- **OPEN**
  - `*_open`=1 and the timer counts.
  - `*_pass`=1 → EVENT.
  - Timer reaches `TIMEOUT_CYCLES`-1 → CLOSE, pulse `gate_timeout`, no event.
- **EVENT**
  - Drive `*_open`=0.
  - Pulse the car strobe for exactly one cycle when granted, then go to CLOSE.
  - If not granted, stay in EVENT with the strobe low.
- **CLOSE**: wait until `*_request`=0 and `*_pass`=0, then → IDLE. This forbids double counting one car.
- **REJECT**: wait until `entry_request`=0, then → IDLE.
- Arbiter rules:
  - Exit EVENT is always granted.
  - Entry EVENT is granted only when exit is not in EVENT in the same cycle.
  - The two strobes are therefore never high together, and each strobe returns low between cars, so the counter sees a clean rising edge per car.
- Vacancy flags are used only in CHECK; later changes do not close an open barrier.
- Timer is 10 bits minimum, sized with `$clog2(TIMEOUT_CYCLES)`. It clears on entry to OPEN and saturates; no wrap.

## Timing
- All outputs are registered.
- Reset values:
  - all strobes 0;
  - `*_open` 0;
  - `is_uni_car_*` 0;
  - both FSMs in IDLE;
  - timers 0.
- Request high at edge n: CHECK in cycle n+1, `*_open`=1 from cycle n+2.
- Denied entry: `entry_denied` high in cycle n+2.
- Pass sensor high at edge k: EVENT in k+1, barrier low in k+1, strobe in k+1 when granted.
- Coincident EVENTs: `car_exited` in cycle k+1, `car_entered` in cycle k+2.
- Timeout: `gate_timeout` and barrier low `TIMEOUT_CYCLES` cycles after OPEN entry.
- `rst_n` low mid-operation: barrier closes asynchronously, any strobe in progress is dropped, FSMs return to IDLE. No event is ever replayed.

## Configuration
- `GATE_TIMEOUT_EN` defined: timer, timeout exit from OPEN, and the `gate_timeout` strobe are present as specified.
- Not defined: no timer. OPEN waits indefinitely for `*_pass`, and `gate_timeout` is tied 0. `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `parking_pkg` holds:
  - the gate state enum (IDLE…REJECT);
  - `OPEN_HOUR_DEFAULT`;
  - capacity constants: uni 500, general 200.
- Sub-module `parking_gate_fsm` is instantiated twice with an `IS_ENTRY` parameter selecting entry admission or unconditional exit.
- Arbiter and top-level output muxing live in `parking_gate_controller`.

## Test plan
- Hour 9, both flags 1, uni request → `entry_open` at cycle 2. Pass at cycle 5 → `car_entered` for one cycle in cycle 6 with `is_uni_car_entered`=1.
- Hour 7, non-uni request → `entry_denied` pulse, barrier never opens. Re-request is ignored until the request drops.
- Hour 14, `uni_is_vacated_space`=0 and `is_vacated_space`=1, uni request → admitted. `is_vacated_space`=0 as well → denied.
- Entry and exit pass asserted on the same edge → `car_exited` in cycle k+1, `car_entered` in cycle k+2, never overlapping.
- Build with `GATE_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, no pass → barrier low and `gate_timeout` after 16 cycles, no strobe. Build without the macro → barrier stays open for 100+ cycles.
- `rst_n` asserted while exit is in EVENT → `car_exited` low immediately and all outputs at reset values. After release, one full exit cycle yields exactly one strobe.
